// File: rtl/sha256_pkg.sv
// Shared constants and FSM state type for the sha256 core arbiter.
package sha256_pkg;

    localparam int unsigned IN_SIZE   = 512;
    localparam int unsigned OUT_SIZE  = 256;
    localparam int unsigned WORD_SIZE = 32;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLaunch  = 3'd1,
        StWait    = 3'd2,
        StCapture = 3'd3,
        StDrain   = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping to 0.
// Expects ptr < N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          valid
);

    logic [PW:0]   sum;
    logic [PW-1:0] idx;
    logic          found;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        sum   = '0;
        idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            // One extra bit so ptr + i can wrap with a single subtraction.
            sum = {1'b0, ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

    assign valid = found;

endmodule

// File: rtl/sha256_arbiter.sv
// Round-robin sequencer sharing one sha256 single-block core between N_REQ requesters.
// Define SHA_ARB_TIMEOUT_EN to add a WAIT/DRAIN watchdog that drives ERR.
module sha256_arbiter
    import sha256_pkg::*;
#(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 200
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [N_REQ-1:0]         REQ,
    input  logic [N_REQ*IN_SIZE-1:0] REQ_DATA,
    output logic [N_REQ-1:0]         GNT,
    output logic [N_REQ-1:0]         ACK,
    output logic [OUT_SIZE-1:0]      DIGEST,
    output logic                     BUSY,
    output logic                     ERR,
    output logic                     CORE_START,
    output logic [IN_SIZE-1:0]       CORE_DATA,
    input  logic                     CORE_DONE,
    input  logic [OUT_SIZE-1:0]      CORE_DIGEST
);

    localparam int unsigned PW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES == 0) begin : g_bad_param
        $error("sha256_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES nonzero");
    end

    arb_state_e         state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic [PW-1:0]      next_ptr;
    logic [N_REQ-1:0]   pick_gnt;
    logic               pick_valid;
    logic [PW-1:0]      pick_idx;
    logic [IN_SIZE-1:0] pick_data;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_rr_pick (
        .req   (REQ),
        .ptr   (ptr),
        .gnt   (pick_gnt),
        .valid (pick_valid)
    );

    always_comb begin
        pick_idx  = '0;
        pick_data = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_gnt[i]) begin
                pick_idx  = PW'(i);
                pick_data = REQ_DATA[i*IN_SIZE +: IN_SIZE];
            end
        end
    end

    // Just-served index gets the lowest priority next round.
    assign next_ptr = (win == PW'(N_REQ - 1)) ? '0 : win + PW'(1);

`ifdef SHA_ARB_TIMEOUT_EN
    localparam int unsigned WdW      = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    localparam logic [WdW-1:0] WdLimit = WdW'(TIMEOUT_CYCLES - 1);

    logic [WdW-1:0] wd_cnt;
    logic           err_q;

    assign ERR = err_q;
`else
    assign ERR = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= StIdle;
            ptr        <= '0;
            win        <= '0;
            GNT        <= '0;
            ACK        <= '0;
            DIGEST     <= '0;
            BUSY       <= 1'b0;
            CORE_START <= 1'b0;
            CORE_DATA  <= '0;
`ifdef SHA_ARB_TIMEOUT_EN
            wd_cnt     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            CORE_START <= 1'b0;
            ACK        <= '0;
`ifdef SHA_ARB_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
            unique case (state)
                StIdle: begin
                    if (pick_valid) begin
                        GNT       <= pick_gnt;
                        win       <= pick_idx;
                        CORE_DATA <= pick_data;
                        BUSY      <= 1'b1;
                        state     <= StLaunch;
                    end
                end
                StLaunch: begin
                    CORE_START <= 1'b1;
                    state      <= StWait;
`ifdef SHA_ARB_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                end
                StWait: begin
                    if (CORE_DONE) begin
                        state <= StCapture;
`ifdef SHA_ARB_TIMEOUT_EN
                    end else if (wd_cnt == WdLimit) begin
                        // Core hung: complete the job with a zero digest and flag it.
                        err_q  <= 1'b1;
                        ACK    <= GNT;
                        GNT    <= '0;
                        DIGEST <= '0;
                        ptr    <= next_ptr;
                        wd_cnt <= '0;
                        state  <= StDrain;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                StCapture: begin
                    DIGEST <= CORE_DIGEST;
                    ACK    <= GNT;
                    GNT    <= '0;
                    ptr    <= next_ptr;
                    state  <= StDrain;
`ifdef SHA_ARB_TIMEOUT_EN
                    wd_cnt <= '0;
`endif
                end
                StDrain: begin
                    // A DONE still high here belongs to the finished job.
                    if (!CORE_DONE) begin
                        BUSY  <= 1'b0;
                        state <= StIdle;
`ifdef SHA_ARB_TIMEOUT_EN
                    end else if (wd_cnt == WdLimit) begin
                        err_q <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= StIdle;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
